regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file, the successor to the single-write/dual-read rv32i register file. It adds configurable width, depth, read and write port counts, same-cycle write-to-read bypass and a hardwired-zero option. A reset/clear sequencer zeroes every entry after reset or on request. It sits in the decode stage of the single-cycle and future pipelined cores; reads are combinational so a single-cycle datapath still closes in one clock.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of registers; power of two, ≥ 2; AW = $clog2(NREG)
- NRD, 2, number of read ports (1..4)
- NWR, 1, number of write ports (1..2)
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes
- BYPASS, 1, 1 = a read of an address being written this cycle returns the write data
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ra  in  NRD*AW  read addresses; port k = ra[k*AW +: AW]
- rd  out  NRD*XLEN  read data; port k = rd[k*XLEN +: XLEN]
- write  in  NWR  per-port write enable
- wa  in  NWR*AW  write addresses; port j = wa[j*AW +: AW]
- wd  in  NWR*XLEN  write data; port j = wd[j*XLEN +: XLEN]
- clr_req  in  1  single-cycle pulse requesting a full clear
- busy  out  1  clear sequence in progress; writes ignored and reads return 0

## Operation
- FSM states: CLEAR, IDLE. Counter cnt is AW bits wide.
- rst=1 at a rising edge: state←CLEAR and cnt←0. The storage array is not directly reset; the clear sequence zeroes it.
- CLEAR, each cycle:
  - entry[cnt]←0 and cnt←cnt+1.
  - When cnt=NREG-1, state←IDLE next edge and cnt wraps to 0.
  - All write ports are ignored.
  - clr_req is ignored.
- IDLE, each cycle:
  - For each j with write[j]=1, entry[wa[j]]←wd[j].
  - If ZERO_REG=1 and wa[j]=0, that write is dropped.
  - If two ports write the same address, port NWR-1 wins.
  - clr_req=1: that cycle's writes still commit, then state←CLEAR and cnt←0.
- Reads are combinational, for each port k, in priority order:
  - busy=1: rd_k=0.
  - ZERO_REG=1 and ra_k=0: rd_k=0.
  - BYPASS=1 and some write[j]=1 with wa[j]=ra_k (and the write is not a dropped zero write): rd_k=wd[j]. If several ports match, the highest j wins.
  - Otherwise rd_k=entry[ra_k].
- BYPASS=0: a read returns the pre-edge value, and the written value is visible from the next cycle.

## Timing
- busy = (state==CLEAR). It is 1 during rst and for exactly NREG cycles after rst deasserts.
- The first write accepted is at the edge NREG cycles after the first edge with rst=0.
- rd outputs are 0 during reset and clear. Every entry reads 0 once busy falls.
- Write latency is 1 edge. Bypassed read latency is 0 (same cycle, combinational).
- clr_req in IDLE: busy rises the next cycle and stays high NREG cycles.
- rst mid-clear: cnt restarts at 0 and the full NREG-cycle clear repeats.
- rst has priority over clr_req and writes.
- Unknown write data on disabled ports has no effect.
- Design has no combinational path from rd to any input. The path from wd/wa to rd exists only when BYPASS=1.

## Test plan
- Reset clear (NREG=32): hold rst 3 cycles, then release.
  - busy=1 for exactly 32 cycles.
  - A write of 0xDEADBEEF to x5 during busy is ignored.
  - After busy falls, every rd reads 0 on both ports.
- Random write/read, 1000 rounds × 32 addresses with seeded random data:
  - Write each address.
  - Read it back on a randomly chosen port one cycle later.
  - Data must match, and x0 must read 0.
- Bypass (BYPASS=1):
  - Write x7=0x12345678 with ra0=7 in the same cycle: rd0=0x12345678 that cycle.
  - With BYPASS=0: rd0 shows the old value that cycle and 0x12345678 the next.
- Dual write (NWR=2):
  - Port0 writes x3=0x1 and port1 writes x3=0x2 in the same cycle: x3 reads 0x2.
  - Port0 writes x0=0xFF: x0 reads 0 (ZERO_REG=1). With ZERO_REG=0, x0 reads 0xFF.
- clr_req with concurrent write:
  - Fill all entries with 0xA5A5A5A5.
  - Pulse clr_req together with a write of x9=0x55: busy=1 for 32 cycles, then all entries read 0.
- Reset mid-clear:
  - Assert rst at cnt=10 during a clear: busy stays high for 32 full cycles after rst release.
  - All entries then read 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-to-read bypass,
// optional hardwired-zero entry and a sequential clear after reset or on request.
module regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic [NWR-1:0]      write,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                clr_req,
  output logic                busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   mem_q [NREG];
  logic [NWR-1:0]    wen_c;
  logic [XLEN-1:0]   rdata_c;

  // Clear in progress: writes blocked and reads forced to zero
  assign busy = (state_q == CLEAR);

  // Effective per-port write enable: only in IDLE, writes to a hardwired zero entry dropped
  always_comb begin
    wen_c = '0;
    for (int j = 0; j < int'(NWR); j++) begin
      wen_c[j] = write[j] && (state_q == IDLE) &&
                 !((ZERO_REG != 0) && (wa[j*AW +: AW] == '0));
    end
  end

  // Sequencer state and clear counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: walk every entry while clearing, re-enter clear on request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage update: zero one entry per clear cycle, otherwise commit writes (highest port last wins)
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else begin
        for (int j = 0; j < int'(NWR); j++) begin
          if (wen_c[j]) begin
            mem_q[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // Combinational read: busy, then zero entry, then bypass (highest port wins), then storage
  always_comb begin
    rd      = '0;
    rdata_c = '0;
    for (int k = 0; k < int'(NRD); k++) begin
      rdata_c = mem_q[ra[k*AW +: AW]];
      if (BYPASS != 0) begin
        for (int j = 0; j < int'(NWR); j++) begin
          if (wen_c[j] && (wa[j*AW +: AW] == ra[k*AW +: AW])) begin
            rdata_c = wd[j*XLEN +: XLEN];
          end
        end
      end
      if (busy || ((ZERO_REG != 0) && (ra[k*AW +: AW] == '0))) begin
        rdata_c = '0;
      end
      rd[k*XLEN +: XLEN] = rdata_c;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (dual-write/bypass/zero-reg and
// single-write/no-bypass/no-zero-reg) checked every cycle against an array model.
module tb_regfile_mp;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_req = 1'b0;

  logic [NRD*AW-1:0]   a_ra = '0;
  logic [NRD*XLEN-1:0] a_rd;
  logic [1:0]          a_write = '0;
  logic [2*AW-1:0]     a_wa = '0;
  logic [2*XLEN-1:0]   a_wd = '0;
  logic                a_busy;

  logic [NRD*AW-1:0]   b_ra = '0;
  logic [NRD*XLEN-1:0] b_rd;
  logic [0:0]          b_write = '0;
  logic [AW-1:0]       b_wa = '0;
  logic [XLEN-1:0]     b_wd = '0;
  logic                b_busy;

  // Reference model: register contents and remaining clear cycles
  logic [XLEN-1:0] ma [NREG];
  logic [XLEN-1:0] mb [NREG];
  int clr_left = NREG;
  int checks = 0;
  int errors = 0;

  int jw, jo, kp, prev;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .ra(a_ra), .rd(a_rd), .write(a_write), .wa(a_wa), .wd(a_wd),
    .clr_req(clr_req), .busy(a_busy)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(1), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .ra(b_ra), .rd(b_rd), .write(b_write), .wa(b_wa), .wd(b_wd),
    .clr_req(clr_req), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < int'(NREG); i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
  endtask

  // Expected read on instance A: busy / zero entry / bypass / stored value
  function automatic logic [31:0] exp_a(input int k);
    logic [AW-1:0] ad;
    logic [31:0]   v;
    ad = a_ra[k*AW +: AW];
    if (clr_left > 0 || ad == '0) return 32'h0;
    v = ma[ad];
    for (int j = 0; j < 2; j++) begin
      if (a_write[j] && a_wa[j*AW +: AW] == ad) v = a_wd[j*XLEN +: XLEN];
    end
    return v;
  endfunction

  // Expected read on instance B: no bypass, entry 0 is ordinary
  function automatic logic [31:0] exp_b(input int k);
    if (clr_left > 0) return 32'h0;
    return mb[b_ra[k*AW +: AW]];
  endfunction

  // Advance one edge and apply that edge's effect to the model
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      clr_left = NREG;
      zero_model();
    end else if (clr_left > 0) begin
      clr_left--;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (a_write[j] && a_wa[j*AW +: AW] != '0) ma[a_wa[j*AW +: AW]] = a_wd[j*XLEN +: XLEN];
      end
      if (b_write[0]) mb[b_wa] = b_wd;
      if (clr_req) begin
        clr_left = NREG;
        zero_model();
      end
    end
    #1;
  endtask

  task automatic check_outputs(input string tag);
    #2;
    for (int k = 0; k < int'(NRD); k++) begin
      check({tag, "_a_rd"}, a_rd[k*XLEN +: XLEN], exp_a(k));
      check({tag, "_b_rd"}, b_rd[k*XLEN +: XLEN], exp_b(k));
    end
    check({tag, "_a_busy"}, 32'(a_busy), 32'(clr_left > 0));
    check({tag, "_b_busy"}, 32'(b_busy), 32'(clr_left > 0));
  endtask

  task automatic idle();
    a_write = '0;
    b_write = '0;
    clr_req = 1'b0;
  endtask

  // Count busy cycles (bounded) and require exactly NREG
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    forever begin
      check_outputs(tag);
      if (a_busy !== 1'b1 || n >= 200) break;
      n++;
      tick();
    end
    check({tag, "_len"}, 32'(n), 32'(NREG));
  endtask

  task automatic read_all(input string tag);
    idle();
    for (int i = 0; i < int'(NREG); i++) begin
      a_ra = {AW'(NREG - 1 - i), AW'(i)};
      b_ra = {AW'(NREG - 1 - i), AW'(i)};
      check_outputs(tag);
      check({tag, "_a_zero"}, a_rd[0 +: XLEN], 32'h0);
      check({tag, "_b_zero"}, b_rd[0 +: XLEN], 32'h0);
      tick();
    end
  endtask

  task automatic fill(input logic [31:0] val);
    idle();
    for (int i = 0; i < int'(NREG); i++) begin
      a_write = 2'b01; a_wa[0 +: AW] = AW'(i); a_wd[0 +: XLEN] = val;
      b_write = 1'b1;  b_wa = AW'(i);          b_wd = val;
      tick();
    end
    idle();
  endtask

  initial begin
    zero_model();
    prev = 0;

    // Reset held 3 cycles, then clear with an ignored write to x5
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outputs("rst");
    end
    rst = 1'b0;
    a_write = 2'b01; a_wa[0 +: AW] = AW'(5); a_wd[0 +: XLEN] = 32'hDEADBEEF;
    b_write = 1'b1;  b_wa = AW'(5);          b_wd = 32'hDEADBEEF;
    wait_clear("rst_clear");
    read_all("post_rst");

    // Randomised write then read-back one cycle later on a random port
    for (int r = 0; r < 1000; r++) begin
      for (int i = 0; i < int'(NREG); i++) begin
        jw = int'($urandom_range(1, 0));
        jo = 1 - jw;
        a_write[jw] = 1'b1;
        a_wa[jw*AW +: AW] = AW'(i);
        a_wd[jw*XLEN +: XLEN] = $urandom;
        a_write[jo] = ($urandom_range(3, 0) == 0);
        a_wa[jo*AW +: AW] = AW'($urandom_range(NREG - 1, 0));
        a_wd[jo*XLEN +: XLEN] = $urandom;
        kp = int'($urandom_range(1, 0));
        a_ra[kp*AW +: AW] = AW'(prev);
        a_ra[(1-kp)*AW +: AW] = AW'($urandom_range(NREG - 1, 0));
        b_write = 1'b1; b_wa = AW'(i); b_wd = $urandom;
        b_ra[kp*AW +: AW] = AW'(prev);
        b_ra[(1-kp)*AW +: AW] = AW'($urandom_range(NREG - 1, 0));
        check_outputs("rand");
        tick();
        prev = i;
      end
    end
    idle();

    // Bypass versus registered visibility
    a_write = 2'b01; a_wa[0 +: AW] = AW'(7); a_wd[0 +: XLEN] = 32'hCAFEF00D;
    b_write = 1'b1;  b_wa = AW'(7);          b_wd = 32'hCAFEF00D;
    tick();
    a_wd[0 +: XLEN] = 32'h12345678; a_ra[0 +: AW] = AW'(7);
    b_wd = 32'h12345678;            b_ra[0 +: AW] = AW'(7);
    check_outputs("byp");
    check("byp_same_cycle", a_rd[0 +: XLEN], 32'h12345678);
    check("nobyp_old", b_rd[0 +: XLEN], 32'hCAFEF00D);
    tick();
    idle();
    check_outputs("byp_next");
    check("nobyp_next", b_rd[0 +: XLEN], 32'h12345678);

    // Dual write to same address, highest port wins
    a_write = 2'b11;
    a_wa = {AW'(3), AW'(3)};
    a_wd = {32'h2, 32'h1};
    tick();
    idle();
    a_ra[0 +: AW] = AW'(3);
    check_outputs("dual");
    check("dual_last_wins", a_rd[0 +: XLEN], 32'h2);

    // Writes to entry 0: dropped with zero reg, kept without
    a_write = 2'b01; a_wa[0 +: AW] = '0; a_wd[0 +: XLEN] = 32'hFF;
    b_write = 1'b1;  b_wa = '0;          b_wd = 32'hFF;
    tick();
    idle();
    a_ra[0 +: AW] = '0;
    b_ra[0 +: AW] = '0;
    check_outputs("x0");
    check("x0_zero_reg", a_rd[0 +: XLEN], 32'h0);
    check("x0_plain", b_rd[0 +: XLEN], 32'hFF);

    // Clear request together with a write
    fill(32'hA5A5A5A5);
    clr_req = 1'b1;
    a_write = 2'b01; a_wa[0 +: AW] = AW'(9); a_wd[0 +: XLEN] = 32'h55;
    b_write = 1'b1;  b_wa = AW'(9);          b_wd = 32'h55;
    tick();
    idle();
    wait_clear("clr");
    read_all("post_clr");

    // Reset in the middle of a clear restarts the full sequence
    fill(32'h5A5A5A5A);
    clr_req = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    check_outputs("mid_rst");
    tick();
    rst = 1'b0;
    wait_clear("mid_clear");
    read_all("post_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
